// File: rtl/sp_ram_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter.
// Holds FSM encodings and port identifiers.
package sp_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        RR     = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arbState_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Lock state that belongs to a given port.
    function automatic arbState_e lockStateOf(input logic port);
        return (port == PORT_A) ? LOCK_A : LOCK_B;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM with byte write enables.
// Registered, read-before-write read port.
module sp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 512,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH),
    localparam int WREN_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clkIn,
    input  logic [ADDR_WIDTH-1:0] addrIn,
    input  logic [WREN_WIDTH-1:0] wrEnIn,
    input  logic [DATA_WIDTH-1:0] wrDataIn,
    input  logic                  rdEnIn,
    output logic [DATA_WIDTH-1:0] rdDataOut
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] mergedWord;

    // Merge write data into the current word under the byte enables.
    always_comb begin
        mergedWord = mem[addrIn];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (wrEnIn[i/8]) begin
                mergedWord[i] = wrDataIn[i];
            end
        end
    end

    // Array update and read register; the read sees the old word.
    always_ff @(posedge clkIn) begin
        if (|wrEnIn) begin
            mem[addrIn] <= mergedWord;
        end
        if (rdEnIn) begin
            rdDataOut <= mem[addrIn];
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin arbiter with lock in front of one sp_ram.
// Read data returns one cycle after grant, acked to its owner.
module sp_ram_arbiter
    import sp_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 512,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH),
    localparam int WREN_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  aReqIn,
    input  logic                  aLockIn,
    input  logic [ADDR_WIDTH-1:0] aAddrIn,
    input  logic [WREN_WIDTH-1:0] aWrEnIn,
    input  logic [DATA_WIDTH-1:0] aWrDataIn,
    input  logic                  aRdEnIn,
    output logic                  aGntOut,
    output logic [DATA_WIDTH-1:0] aRdDataOut,
    output logic                  aRdAckOut,
    input  logic                  bReqIn,
    input  logic                  bLockIn,
    input  logic [ADDR_WIDTH-1:0] bAddrIn,
    input  logic [WREN_WIDTH-1:0] bWrEnIn,
    input  logic [DATA_WIDTH-1:0] bWrDataIn,
    input  logic                  bRdEnIn,
    output logic                  bGntOut,
    output logic [DATA_WIDTH-1:0] bRdDataOut,
    output logic                  bRdAckOut
);

    arbState_e state;
    arbState_e nextState;
    logic      lastGnt;
    logic      nextLastGnt;
    logic      rrPickA;
    logic      rrPickB;
    logic      aGnt;
    logic      bGnt;

    logic                  rdPending;
    logic                  rdOwner;

    logic [ADDR_WIDTH-1:0] ramAddr;
    logic [WREN_WIDTH-1:0] ramWrEn;
    logic [DATA_WIDTH-1:0] ramWrData;
    logic                  ramRdEn;
    logic [DATA_WIDTH-1:0] ramRdData;

    // Round-robin pick; the two picks are mutually exclusive.
    always_comb begin
        rrPickA = aReqIn && (!bReqIn || lastGnt == PORT_B);
        rrPickB = bReqIn && (!aReqIn || lastGnt == PORT_A);
    end

    // Grant decode and next-state logic.
    always_comb begin
        aGnt        = 1'b0;
        bGnt        = 1'b0;
        nextState   = state;
        nextLastGnt = lastGnt;
        unique case (state)
            RR: begin
                if (rrPickA) begin
                    aGnt        = 1'b1;
                    nextLastGnt = PORT_A;
                    if (aLockIn) begin
                        nextState = lockStateOf(PORT_A);
                    end
                end else if (rrPickB) begin
                    bGnt        = 1'b1;
                    nextLastGnt = PORT_B;
                    if (bLockIn) begin
                        nextState = lockStateOf(PORT_B);
                    end
                end
            end
            LOCK_A: begin
                if (aReqIn) begin
                    aGnt        = 1'b1;
                    nextLastGnt = PORT_A;
                end
                if (!aLockIn) begin
                    nextState   = RR;
                    nextLastGnt = PORT_A;
                end
            end
            LOCK_B: begin
                if (bReqIn) begin
                    bGnt        = 1'b1;
                    nextLastGnt = PORT_B;
                end
                if (!bLockIn) begin
                    nextState   = RR;
                    nextLastGnt = PORT_B;
                end
            end
            default: begin
                nextState = RR;
            end
        endcase
        if (rstIn) begin
            aGnt = 1'b0;
            bGnt = 1'b0;
        end
    end

    // Arbiter state and round-robin history.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state   <= RR;
            lastGnt <= PORT_B;
        end else begin
            state   <= nextState;
            lastGnt <= nextLastGnt;
        end
    end

    // Steer the granted port onto the RAM; idle cycles do nothing.
    always_comb begin
        ramAddr   = bGnt ? bAddrIn : aAddrIn;
        ramWrData = bGnt ? bWrDataIn : aWrDataIn;
        ramWrEn   = '0;
        ramRdEn   = 1'b0;
        if (aGnt) begin
            ramWrEn = aWrEnIn;
            ramRdEn = aRdEnIn;
        end else if (bGnt) begin
            ramWrEn = bWrEnIn;
            ramRdEn = bRdEnIn;
        end
    end

    // Remember who issued the read so the ack goes back to them.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            rdPending <= 1'b0;
            rdOwner   <= PORT_A;
        end else begin
            rdPending <= ramRdEn;
            if (ramRdEn) begin
                rdOwner <= bGnt ? PORT_B : PORT_A;
            end
        end
    end

    sp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) uRam (
        .clkIn    (clkIn),
        .addrIn   (ramAddr),
        .wrEnIn   (ramWrEn),
        .wrDataIn (ramWrData),
        .rdEnIn   (ramRdEn),
        .rdDataOut(ramRdData)
    );

    assign aGntOut    = aGnt;
    assign bGntOut    = bGnt;
    assign aRdDataOut = ramRdData;
    assign bRdDataOut = ramRdData;
    assign aRdAckOut  = rdPending && (rdOwner == PORT_A);
    assign bRdAckOut  = rdPending && (rdOwner == PORT_B);

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter.
// Directed scenarios followed by randomized two-port traffic.
module tb_sp_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int WW = 4;

    logic          clkIn = 1'b0;
    logic          rstIn = 1'b1;
    logic          aReq = 0, aLock = 0, aRdEn = 0;
    logic [AW-1:0] aAddr = '0;
    logic [WW-1:0] aWrEn = '0;
    logic [DW-1:0] aWrData = '0;
    logic          bReq = 0, bLock = 0, bRdEn = 0;
    logic [AW-1:0] bAddr = '0;
    logic [WW-1:0] bWrEn = '0;
    logic [DW-1:0] bWrData = '0;
    logic          aGnt, bGnt, aAck, bAck;
    logic [DW-1:0] aRdData, bRdData;

    sp_ram_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(512)) dut (
        .clkIn(clkIn), .rstIn(rstIn),
        .aReqIn(aReq), .aLockIn(aLock), .aAddrIn(aAddr),
        .aWrEnIn(aWrEn), .aWrDataIn(aWrData), .aRdEnIn(aRdEn),
        .aGntOut(aGnt), .aRdDataOut(aRdData), .aRdAckOut(aAck),
        .bReqIn(bReq), .bLockIn(bLock), .bAddrIn(bAddr),
        .bWrEnIn(bWrEn), .bWrDataIn(bWrData), .bRdEnIn(bRdEn),
        .bGntOut(bGnt), .bRdDataOut(bRdData), .bRdAckOut(bAck)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        int          port;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [16];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lockOwner = -1;
    int          lastWinner = 1;
    logic        gotA, gotB;
    logic [31:0] lastAckA = '0, lastAckB = '0;

    always @(posedge clkIn) cyc <= cyc + 1;

    // Monitor: acks must appear exactly one cycle after a read grant.
    always @(negedge clkIn) begin
        logic expA, expB;
        while (q.size() > 0 && q[0].due < cyc) begin
            miscompares++;
            $display("FAIL lostAck cyc=%0d port=%0d not acked", cyc, q[0].port);
            void'(q.pop_front());
        end
        expA = q.size() > 0 && q[0].due == cyc && q[0].port == 0;
        expB = q.size() > 0 && q[0].due == cyc && q[0].port == 1;
        vectors++;
        if (aAck !== expA || bAck !== expB) begin
            miscompares++;
            $display("FAIL ack cyc=%0d got a=%b b=%b want a=%b b=%b",
                     cyc, aAck, bAck, expA, expB);
        end
        if ((aAck && expA) || (bAck && expB)) begin
            logic [31:0] d;
            d = expA ? aRdData : bRdData;
            vectors++;
            if (d !== q[0].data) begin
                miscompares++;
                $display("FAIL rdData cyc=%0d port=%0d got %h want %h",
                         cyc, q[0].port, d, q[0].data);
            end
            if (expA) lastAckA = d;
            else lastAckB = d;
            void'(q.pop_front());
        end
    end

    // One clock of the reference model against the DUT grants.
    task automatic step();
        int          w;
        logic [8:0]  ad;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        rd, lk;
        @(negedge clkIn);
        w = -1;
        if (!rstIn) begin
            if (lockOwner < 0) begin
                if (aReq && bReq) w = 1 - lastWinner;
                else if (aReq) w = 0;
                else if (bReq) w = 1;
            end else if ((lockOwner == 0) ? aReq : bReq) begin
                w = lockOwner;
            end
        end
        gotA = (w == 0);
        gotB = (w == 1);
        vectors++;
        if (aGnt !== gotA || bGnt !== gotB) begin
            miscompares++;
            $display("FAIL grant cyc=%0d got a=%b b=%b want a=%b b=%b",
                     cyc, aGnt, bGnt, gotA, gotB);
        end
        if (w >= 0) begin
            ad = (w == 0) ? aAddr : bAddr;
            we = (w == 0) ? aWrEn : bWrEn;
            wd = (w == 0) ? aWrData : bWrData;
            rd = (w == 0) ? aRdEn : bRdEn;
            lk = (w == 0) ? aLock : bLock;
            if (rd) q.push_back('{port: w, due: cyc + 1, data: mem[ad[3:0]]});
            for (int k = 0; k < 4; k++)
                if (we[k]) mem[ad[3:0]][k*8 +: 8] = wd[k*8 +: 8];
            lastWinner = w;
            lockOwner  = lk ? w : -1;
        end else if (!rstIn && lockOwner >= 0) begin
            if (!((lockOwner == 0) ? aLock : bLock)) begin
                lastWinner = lockOwner;
                lockOwner  = -1;
            end
        end
        @(posedge clkIn);
        #1;
    endtask

    task automatic setA(input logic r, input logic l, input int ad,
                        input logic [3:0] we, input logic [31:0] wd,
                        input logic rd);
        aReq = r; aLock = l; aAddr = AW'(ad);
        aWrEn = we; aWrData = wd; aRdEn = rd;
    endtask

    task automatic setB(input logic r, input logic l, input int ad,
                        input logic [3:0] we, input logic [31:0] wd,
                        input logic rd);
        bReq = r; bLock = l; bAddr = AW'(ad);
        bWrEn = we; bWrData = wd; bRdEn = rd;
    endtask

    task automatic idle();
        setA(0, 0, 0, 4'h0, 32'h0, 0);
        setB(0, 0, 0, 4'h0, 32'h0, 0);
    endtask

    task automatic enterReset();
        rstIn = 1'b1;
        q.delete();
        lockOwner  = -1;
        lastWinner = 1;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic aBusy, bBusy;
        @(posedge clkIn); #1;
        enterReset();
        step(); step();
        rstIn = 1'b0;

        // Preload the 16 words used by the bench.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            v = (i == 1) ? 32'h11 : (i == 2) ? 32'h22 :
                (i == 9) ? 32'h1234 : 32'(i) * 32'h01010101;
            setA(1, 0, i, 4'hF, v, 0);
            step();
        end
        idle();

        // Write then read back on port A.
        setA(1, 0, 5, 4'hF, 32'hDEADBEEF, 0); step();
        setA(1, 0, 5, 4'h0, 32'h0, 1); step();
        idle(); step();
        check("readBackA", lastAckA, 32'hDEADBEEF);

        // B access so that A wins the next contention.
        setB(1, 0, 0, 4'h0, 32'h0, 0); step();
        setA(1, 0, 1, 4'h0, 32'h0, 1);
        setB(1, 0, 2, 4'h0, 32'h0, 1);
        for (int i = 0; i < 6; i++) step();
        idle(); step();
        check("alternateA", lastAckA, 32'h11);
        check("alternateB", lastAckB, 32'h22);

        // Locked read-modify-write by A with B waiting.
        setA(1, 1, 3, 4'h0, 32'h0, 1);
        setB(1, 0, 3, 4'h0, 32'h0, 1);
        step();
        setA(1, 0, 3, 4'hF, 32'h33CC, 0); step();
        setA(0, 0, 0, 4'h0, 32'h0, 0); step();
        idle(); step();
        check("lockedRmw", lastAckB, 32'h33CC);

        // Byte enables on port B.
        setB(1, 0, 7, 4'hF, 32'hAABBCCDD, 0); step();
        setB(1, 0, 7, 4'b0010, 32'h00001100, 0); step();
        setB(1, 0, 7, 4'h0, 32'h0, 1); step();
        idle(); step();
        check("byteEnable", lastAckB, 32'hAABB11DD);

        // Read and write in one access returns the old word.
        setA(1, 0, 9, 4'hF, 32'h5678, 1); step();
        setA(1, 0, 9, 4'h0, 32'h0, 1); step();
        check("readBeforeWrite", lastAckA, 32'h1234);
        idle(); step();
        check("readAfterWrite", lastAckA, 32'h5678);

        // Reset right after a B read grant drops that read.
        setB(1, 0, 7, 4'h0, 32'h0, 1); step();
        enterReset();
        setA(1, 0, 5, 4'h0, 32'h0, 1);
        setB(1, 0, 7, 4'h0, 32'h0, 1);
        step(); step();
        rstIn = 1'b0;
        step();
        check("aFirstAfterReset", {31'b0, gotA}, 32'h1);
        idle(); step();
        check("ramKeptOverReset", lastAckA, 32'hDEADBEEF);
        idle(); step();

        // Randomized traffic on both ports.
        aBusy = 0;
        bBusy = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!aBusy && $urandom_range(0, 9) < 7) begin
                setA(1, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
                     4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
                aBusy = 1;
            end else if (!aBusy) begin
                setA(0, $urandom_range(0, 7) == 0, 0, 4'h0, 32'h0, 0);
            end
            if (!bBusy && $urandom_range(0, 9) < 7) begin
                setB(1, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
                     4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
                bBusy = 1;
            end else if (!bBusy) begin
                setB(0, $urandom_range(0, 7) == 0, 0, 4'h0, 32'h0, 0);
            end
            step();
            if (gotA) aBusy = 0;
            if (gotB) bBusy = 0;
        end
        idle();
        step(); step(); step();
        check("queueDrained", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Shares one single-port RAM (sp_ram instance inside this block) between two requesters: port A (RISC-V core load/store) and port B (accelerator datapath). Arbitration is round-robin per access, with a lock so one port can hold the RAM for a read-modify-write sequence. Read data returns one cycle after grant, with the read ack steered to the owning port.

Parameters:
DATA_WIDTH, 32, word width of RAM and both ports
RAM_DEPTH, 512, RAM words; ADDR_WIDTH = $clog2(RAM_DEPTH), WREN_WIDTH = (DATA_WIDTH+7)/8 (derived localparams)

Ports:
clkIn  in  1  clock
rstIn  in  1  reset, asynchronous, active-high
aReqIn  in  1  port A access request (level, held until granted)
aLockIn  in  1  port A requests to keep ownership after this access
aAddrIn  in  ADDR_WIDTH  port A word address
aWrEnIn  in  WREN_WIDTH  port A byte write enables
aWrDataIn  in  DATA_WIDTH  port A write data
aRdEnIn  in  1  port A read request
aGntOut  out  1  port A access accepted this cycle
aRdDataOut  out  DATA_WIDTH  port A read data, valid with aRdAckOut
aRdAckOut  out  1  port A read data valid
bReqIn, bLockIn, bAddrIn, bWrEnIn, bWrDataIn, bRdEnIn, bGntOut, bRdDataOut, bRdAckOut: same as port A, for port B

Behaviour:
- Grant is combinational in the request cycle. A request with aGnt/bGnt high is issued to the RAM that same clock edge; a non-granted request must be held stable by the requester.
- At most one grant per cycle. While rstIn is high, both grants are forced to 0.
- FSM (registered), states: RR, LOCK_A, LOCK_B. Reset state is RR with lastGnt=B, so A wins the first contention.
- RR state:
  - Single requester is granted.
  - Both requesting: the port not equal to lastGnt is granted.
  - lastGnt updates on every grant.
  - Granted port with its lock high goes to LOCK_A or LOCK_B.
- LOCK_x state:
  - Only port x may be granted; the other port's requests stall with no grant.
  - Leaves to RR (lastGnt=x) on a cycle where x is granted with lock low, or where x has req=0 and lock=0.
  - Lock high with no request holds the state (idle ownership).
- Muxing to the RAM:
  - The granted port drives addr, wrEn, wrData and rdEn.
  - With no grant: wrEn=0 and rdEn=0. Address is don't-care but is driven from port A for determinism.
- Read latency is 1 cycle: ack and data are valid on the cycle after the grant.
  - rdOwner register captures the granted port when rdEn is high.
  - Only that port's RdAck pulses.
  - Both RdData outputs carry the RAM read register.
  - Data is undefined without ack.
- A read and a write in the same access are allowed. Read returns pre-write contents (RAM is read-before-write).
- Back-to-back grants to alternating ports each cycle give full RAM throughput. Each ack goes to the correct port in order.
- Reset mid-operation: FSM returns to RR/lastGnt=B, acks clear to 0 immediately, any in-flight read is dropped. RAM contents are not cleared.
- Reset values: aGntOut=0, bGntOut=0, aRdAckOut=0, bRdAckOut=0. RdData is undefined (not reset).

Decomposition:
- Shared package holds the FSM state encoding (RR=2'd0, LOCK_A=2'd1, LOCK_B=2'd2) and port-ID constants (PORT_A=1'b0, PORT_B=1'b1) for reuse by a later N-port version.
- One sub-module: sp_ram (DATA_WIDTH, RAM_DEPTH passed through).
- Grant logic, FSM and rdOwner live in this module.

Test Plan:
- Reset, then A writes 0xDEADBEEF to addr 5 with wrEn=0xF; next cycle A reads addr 5 -> aGnt high both cycles; aRdAck pulses one cycle after the read grant with aRdData=0xDEADBEEF; bRdAck stays 0.
- A and B both request reads continuously (addr 1 and addr 2, preloaded with 0x11 and 0x22) -> grants alternate A,B,A,B starting with A; acks alternate with matching data 0x11/0x22 every cycle.
- A locks: read addr 3 with aLock=1, then write addr 3 with aLock=0, while B requests throughout -> bGnt stays 0 until A's unlocking write is granted; B is granted the next cycle; B's read of addr 3 returns A's value.
- Byte enables: B writes 0xAABBCCDD to addr 7, then writes 0x00001100 with wrEn=4'b0010 -> read returns 0xAABB11DD.
- Same-cycle read+write: A at addr 9 (old value 0x1234) writes 0x5678 with rdEn=1 -> ack returns 0x1234; a following read returns 0x5678.
- Assert rstIn in the cycle after a B read grant -> bRdAck stays 0; FSM back in RR; with both requesting, A is granted first after reset release; earlier-written RAM data is still readable.
